qar_dmem_responder: RTL and testbench

QAR_DMEM_RESPONDER -- requirements
Module: qar_dmem_responder

---
 rtl/qar_pkg.sv | 24 ++
 rtl/qar_lfsr16.sv | 31 +++
 rtl/qar_dmem_responder.sv | 143 ++++++++++++++
 tb/tb_qar_dmem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/qar_pkg.sv
// Shared definitions for the QAR data-memory responder.
//   BUS_W          - core data/address bus width
//   LFSR_SEED_DEF  - default reset value of the wait-state LFSR
//   state_e        - responder FSM state encodings
//   lfsr16_next    - one step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR
package qar_pkg;

    localparam int          BUS_W         = 32;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Right-shifting form: bit 0 is the oldest bit, taps 16/14/13/11 map
    // to bit positions 0/2/3/5.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/qar_lfsr16.sv
// 16-bit maximal-length LFSR used to draw pseudo-random wait counts.
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, loads SEED
//   advance - step the sequence by one on this edge
//   value   - current LFSR state
module qar_lfsr16
    import qar_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (advance) value_d = lfsr16_next(value_q);
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= SEED;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/qar_dmem_responder.sv
// Single-port data memory with a valid/ready handshake and configurable
// wait states (fixed, or drawn from an LFSR per request).
//   clk, rst   - clock and synchronous active-high reset
//   mem_valid  - request from the core, held until mem_ready
//   mem_we     - 1 = write, 0 = read
//   mem_addr   - byte address; word index is addr[ADDR_WIDTH+1:2]
//   mem_wdata  - write data
//   mem_ready  - one-cycle completion pulse
//   mem_rdata  - last read data, updated only by read responses
//   mem_err    - pulses with mem_ready when the captured address is misaligned
module qar_dmem_responder
  import qar_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_MODE   = 0,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_we,
  input  logic [BUS_W-1:0] mem_addr,
  input  logic [BUS_W-1:0] mem_wdata,
  output logic             mem_ready,
  output logic [BUS_W-1:0] mem_rdata,
  output logic             mem_err
);

  localparam logic [1:0] W_FIX = 2'(WAIT_CYCLES);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            off;
    logic [BUS_W-1:0]      wdata;
  } req_t;

  state_e                state_q, state_d;
  logic [1:0]            count_q, count_d;
  req_t                  req_q, req_d;
  logic [BUS_W-1:0]      rdata_q;

  logic                  capture;
  logic [1:0]            w_new;
  logic [15:0]           lfsr_value;

  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [BUS_W-1:0]      mem [DEPTH];

  logic                  unused_bits;
  assign unused_bits = ^{mem_addr[BUS_W-1:ADDR_WIDTH+2], lfsr_value[15:2]};

  assign capture = (state_q == ST_IDLE) && mem_valid;
  assign w_new   = (WAIT_MODE != 0) ? lfsr_value[1:0] : W_FIX;

  qar_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (capture),
    .value   (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= 2'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          req_d.we    = mem_we;
          req_d.idx   = mem_addr[ADDR_WIDTH+1:2];
          req_d.off   = mem_addr[1:0];
          req_d.wdata = mem_wdata;
          count_d     = w_new;
          state_d     = (w_new == 2'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        count_d = count_q - 2'd1;
        if (count_q <= 2'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_DONE;
      // DONE ignores mem_valid so a request still held high is not
      // captured a second time.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM read is synchronous, so a read is issued on the edge that
  // enters RESP: straight from the bus when W=0, otherwise from the
  // captured request in the last WAIT cycle. Writes commit at the end of
  // RESP. The two never overlap, so one port suffices.
  always_comb begin
    ram_idx = req_q.idx;
    ram_re  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && (w_new == 2'd0)) begin
          ram_idx = mem_addr[ADDR_WIDTH+1:2];
          ram_re  = !mem_we && !rst;
        end
      end
      ST_WAIT: ram_re = (count_q <= 2'd1) && !req_q.we && !rst;
      ST_RESP: ram_we = req_q.we && !rst;
      default: ;
    endcase
  end

  // Single synchronous RAM port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= req_q.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)         rdata_q <= '0;
    else if (ram_re) rdata_q <= mem[ram_idx];
  end

  // Gating with rst keeps the handshake quiet while reset is held, even
  // if reset arrives during the RESP cycle itself.
  assign mem_ready = (state_q == ST_RESP) && !rst;
  assign mem_err   = mem_ready && (req_q.off != 2'd0);
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_qar_dmem_responder.sv
module tb_qar_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [4];
    logic        valid [4];
    logic        we    [4];
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic        ready [4];
    logic        err   [4];
    logic [31:0] rdata [4];

    int checks = 0;
    int errors = 0;

    qar_dmem_responder #(.WAIT_MODE(0), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst[0]), .mem_valid(valid[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0]));
    qar_dmem_responder #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst[1]), .mem_valid(valid[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1]));
    qar_dmem_responder #(.WAIT_MODE(0), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst[2]), .mem_valid(valid[2]), .mem_we(we[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_err(err[2]));
    qar_dmem_responder #(.WAIT_MODE(1), .LFSR_SEED(16'hACE1)) u3 (
        .clk(clk), .rst(rst[3]), .mem_valid(valid[3]), .mem_we(we[3]), .mem_addr(addr[3]),
        .mem_wdata(wdata[3]), .mem_ready(ready[3]), .mem_rdata(rdata[3]), .mem_err(err[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One request on instance i. Latency is counted in cycles after the
    // capture edge; bus fields are scrambled once the request is captured.
    task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
        lat = 0; rd = '0; e = 1'b0;
        we[i] = w; addr[i] = a; wdata[i] = d; valid[i] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (ready[i]) begin
                lat = k; rd = rdata[i]; e = err[i];
                break;
            end
            if (k == 1) begin
                we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
            end
        end
        valid[i] = 1'b0;
        @(posedge clk); #1;
        chk("done_noready", 32'(ready[i]), 0);
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", 32'(ready[i]), 0);
            chk("rst_err",   32'(err[i]),   0);
            chk("rst_rdata", rdata[i],      0);
            rst[i] = 1'b0;
        end

        // ---- fixed W=2: basic write/read, wrap, alignment ----
        txn(0, 1, 32'h40, 32'h12345678, lat, rd, e);
        chk("w2_wr_lat", lat, 3);
        chk("w2_wr_err", 32'(e), 0);
        chk("w2_wr_rdata_hold", rd, 0);
        txn(0, 0, 32'h40, 32'h0, lat, rd, e);
        chk("w2_rd_lat", lat, 3);
        chk("w2_rd_data", rd, 32'h12345678);
        chk("w2_rd_err", 32'(e), 0);
        txn(0, 0, 32'hFFFF_F040, 32'h0, lat, rd, e);
        chk("w2_hi_wrap_data", rd, 32'h12345678);
        txn(0, 1, 32'h400, 32'hCAFEF00D, lat, rd, e);
        chk("w2_wr400_rdata_hold", rd, 32'h12345678);
        txn(0, 0, 32'h000, 32'h0, lat, rd, e);
        chk("wrap_data", rd, 32'hCAFEF00D);
        chk("wrap_err", 32'(e), 0);
        txn(0, 0, 32'h002, 32'h0, lat, rd, e);
        chk("mis_data", rd, 32'hCAFEF00D);
        chk("mis_err", 32'(e), 1);
        chk("mis_lat", lat, 3);

        // ---- fixed W=0, valid held high across back-to-back requests ----
        begin
            logic        b_we [4];
            logic [31:0] b_a  [4];
            logic [31:0] b_d  [4];
            logic [31:0] b_ex [4];
            int          cyc, prev, seen;
            b_we = '{1'b1, 1'b1, 1'b0, 1'b0};
            b_a  = '{32'h20, 32'h24, 32'h20, 32'h24};
            b_d  = '{32'hA5A50001, 32'hA5A50002, 32'h0, 32'h0};
            b_ex = '{32'h0, 32'h0, 32'hA5A50001, 32'hA5A50002};
            cyc = 0; prev = 0;
            valid[1] = 1'b1;
            for (int n = 0; n < 4; n++) begin
                we[1] = b_we[n]; addr[1] = b_a[n]; wdata[1] = b_d[n];
                seen = 0;
                for (int k = 0; k < 10 && seen == 0; k++) begin
                    @(posedge clk); #1; cyc++;
                    if (ready[1]) seen = 1;
                end
                chk("b2b_seen", seen, 1);
                chk("b2b_gap", cyc - prev, (n == 0) ? 1 : 3);
                prev = cyc;
                if (!b_we[n]) chk("b2b_rdata", rdata[1], b_ex[n]);
            end
            valid[1] = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end

        // ---- fixed W=3: reset in the 2nd WAIT cycle of a write ----
        begin
            int seen;
            txn(2, 1, 32'h10, 32'h11111111, lat, rd, e);
            chk("w3_wr_lat", lat, 4);
            txn(2, 0, 32'h10, 32'h0, lat, rd, e);
            chk("w3_rd_data", rd, 32'h11111111);
            we[2] = 1'b1; addr[2] = 32'h10; wdata[2] = 32'hFFFFFFFF; valid[2] = 1'b1;
            @(posedge clk); #1;          // 1st WAIT cycle
            seen = 32'(ready[2]);
            @(posedge clk); #1;          // 2nd WAIT cycle
            rst[2] = 1'b1;
            seen |= 32'(ready[2]);
            @(posedge clk); #1;
            seen |= 32'(ready[2]);
            rst[2] = 1'b0; valid[2] = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                seen |= 32'(ready[2]);
            end
            chk("abort_noready", seen, 0);
            chk("abort_rdata_rst", rdata[2], 0);
            txn(2, 0, 32'h10, 32'h0, lat, rd, e);
            chk("abort_word_kept", rd, 32'h11111111);
            chk("abort_rd_lat", lat, 4);
        end

        // ---- WAIT_MODE=1: random traffic against a scoreboard ----
        begin
            logic [31:0] model [16];
            logic [31:0] last_rd;
            int          hist  [5];
            int          idx, off;
            bit          w;
            logic [31:0] a, d;
            last_rd = '0;
            for (int k = 0; k < 5; k++) hist[k] = 0;
            for (int j = 0; j < 16; j++) begin
                d = $urandom;
                txn(3, 1, 32'(j) << 2, d, lat, rd, e);
                chk("rnd_pre_lat", 32'(lat >= 1 && lat <= 4), 1);
                chk("rnd_pre_hold", rd, last_rd);
                model[j] = d;
                if (lat >= 1 && lat <= 4) hist[lat]++;
            end
            for (int t = 0; t < 1000; t++) begin
                w   = 1'($urandom_range(0, 1));
                idx = int'($urandom_range(0, 15));
                off = int'($urandom_range(0, 3));
                a   = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2) | 32'(off);
                d   = $urandom;
                txn(3, w, a, d, lat, rd, e);
                chk("rnd_lat", 32'(lat >= 1 && lat <= 4), 1);
                chk("rnd_err", 32'(e), 32'(off != 0));
                if (w) begin
                    chk("rnd_wr_hold", rd, last_rd);
                    model[idx] = d;
                end else begin
                    chk("rnd_rd_data", rd, model[idx]);
                    last_rd = model[idx];
                end
                if (lat >= 1 && lat <= 4) hist[lat]++;
            end
            for (int k = 1; k <= 4; k++) chk($sformatf("rnd_lat%0d_seen", k), 32'(hist[k] > 0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
